// File: rtl/bnn_seq_core.sv
// bnn_seq_core: two-layer binary neural network core. It evaluates one neuron per
// clock against a runtime-loadable configuration image.
// Latency: the input handshake is at edge E and out_valid rises after edge
// E+HID_N+OUT_N. The minimum inference period is HID_N+OUT_N+2 cycles.
// Backpressure: the core holds one inference at a time. in_ready is low from the
// input handshake until the result is taken. out_data is held in DONE until
// out_ready is seen. ena=0 freezes every register.
//
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   ena                  global enable. When low, no state changes and in_ready/out_valid are masked.
//   in_data/in_valid/in_ready     input vector handshake
//   out_data/out_valid/out_ready  result vector handshake
//   ld_start, ld_en, ld_data      configuration load port (IDLE only)
//   busy                 high whenever an inference is in progress or awaiting hand-off
//   ld_err               sticky load-error flag. Cleared by ld_start in IDLE or by reset.
//
// Image layout, LSB first: hidden weights (neuron h bit i at h*IN_W+i),
// hidden thresholds, output weights (neuron o bit h), output thresholds.
module bnn_seq_core #(
  parameter int IN_W   = 8,
  parameter int HID_N  = 8,
  parameter int OUT_N  = 4,
  parameter int LOAD_W = 4,
  parameter int THR_W  = $clog2(((IN_W > HID_N) ? IN_W : HID_N) + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic [IN_W-1:0]   in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [OUT_N-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready,
  input  logic              ld_start,
  input  logic              ld_en,
  input  logic [LOAD_W-1:0] ld_data,
  output logic              busy,
  output logic              ld_err
);

  // Image field offsets.
  localparam int HW_BITS = HID_N * IN_W;
  localparam int HT_OFF  = HW_BITS;
  localparam int OW_OFF  = HT_OFF + HID_N * THR_W;
  localparam int OT_OFF  = OW_OFF + OUT_N * HID_N;
  localparam int TOTAL   = OT_OFF + OUT_N * THR_W;
  localparam int NBEATS  = (TOTAL + LOAD_W - 1) / LOAD_W;
  localparam int PTR_W   = $clog2(NBEATS + 1);

  localparam int IDX_N   = (HID_N > OUT_N) ? HID_N : OUT_N;
  localparam int IDX_W   = (IDX_N > 1) ? $clog2(IDX_N) : 1;

  // Popcounts are kept at full width, so a count equal to the fan-in is representable.
  localparam int PC1_W   = $clog2(IN_W + 1);
  localparam int PC2_W   = $clog2(HID_N + 1);
  localparam int CMP_A   = (PC1_W > PC2_W) ? PC1_W : PC2_W;
  localparam int CMP_W   = (CMP_A > THR_W) ? CMP_A : THR_W;

  // Reset image: zero weights and mid-scale thresholds.
  function automatic logic [TOTAL-1:0] reset_image();
    logic [TOTAL-1:0] r;
    r = '0;
    for (int h = 0; h < HID_N; h++)
      r[HT_OFF + h*THR_W +: THR_W] = THR_W'(IN_W / 2);
    for (int o = 0; o < OUT_N; o++)
      r[OT_OFF + o*THR_W +: THR_W] = THR_W'(HID_N / 2);
    return r;
  endfunction

  localparam logic [TOTAL-1:0] RST_IMG = reset_image();

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_L1   = 2'd1,
    S_L2   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             state;
  logic [TOTAL-1:0]   img;
  logic [PTR_W-1:0]   ptr;
  logic [IDX_W-1:0]   idx;
  logic [IN_W-1:0]    x_reg;
  logic [HID_N-1:0]   hid_reg;
  logic [OUT_N-1:0]   out_acc;
  logic               out_valid_r;

  // Datapath: one hidden neuron and one output neuron, both selected by idx.
  logic [IN_W-1:0]    h_w;
  logic [THR_W-1:0]   h_thr;
  logic [PC1_W-1:0]   h_pc;
  logic               h_fire;
  logic [HID_N-1:0]   o_w;
  logic [THR_W-1:0]   o_thr;
  logic [PC2_W-1:0]   o_pc;
  logic               o_fire;
  logic [OUT_N-1:0]   out_next;
  int                 hsel;
  int                 osel;

  always_comb begin
    // Clamp the selectors so that idx values meant for the other layer never
    // index past the end of the image.
    hsel = (int'(idx) < HID_N) ? int'(idx) : 0;
    osel = (int'(idx) < OUT_N) ? int'(idx) : 0;

    h_w   = img[hsel*IN_W +: IN_W];
    h_thr = img[HT_OFF + hsel*THR_W +: THR_W];
    h_pc  = '0;
    for (int i = 0; i < IN_W; i++)
      h_pc = h_pc + PC1_W'(~(x_reg[i] ^ h_w[i]));
    h_fire = CMP_W'(h_pc) >= CMP_W'(h_thr);

    o_w   = img[OW_OFF + osel*HID_N +: HID_N];
    o_thr = img[OT_OFF + osel*THR_W +: THR_W];
    o_pc  = '0;
    for (int h = 0; h < HID_N; h++)
      o_pc = o_pc + PC2_W'(~(hid_reg[h] ^ o_w[h]));
    o_fire = CMP_W'(o_pc) >= CMP_W'(o_thr);

    // Accumulated outputs, with the neuron evaluated this cycle merged in.
    out_next = out_acc;
    for (int o = 0; o < OUT_N; o++)
      if (idx == IDX_W'(o)) out_next[o] = o_fire;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      img         <= RST_IMG;
      ptr         <= '0;
      idx         <= '0;
      x_reg       <= '0;
      hid_reg     <= '0;
      out_acc     <= '0;
      out_data    <= '0;
      out_valid_r <= 1'b0;
      busy        <= 1'b0;
      ld_err      <= 1'b0;
    end else if (ena) begin
      // Load traffic outside IDLE is refused and flagged. This includes ld_start,
      // which therefore cannot clear the flag mid-inference.
      if (state != S_IDLE && (ld_en || ld_start))
        ld_err <= 1'b1;

      case (state)
        S_IDLE: begin
          if (ld_start) begin
            // ld_start takes priority over a beat in the same cycle.
            ptr    <= '0;
            ld_err <= 1'b0;
          end else if (ld_en) begin
            if (ptr == PTR_W'(NBEATS)) begin
              ld_err <= 1'b1;
            end else begin
              // Bits of the last beat that fall past TOTAL have no image bit and are dropped.
              for (int j = 0; j < TOTAL; j++)
                if (j / LOAD_W == int'(ptr))
                  img[j] <= ld_data[j % LOAD_W];
              ptr <= ptr + PTR_W'(1);
            end
          end else if (in_valid) begin
            x_reg <= in_data;
            idx   <= '0;
            busy  <= 1'b1;
            state <= S_L1;
          end
        end

        S_L1: begin
          for (int h = 0; h < HID_N; h++)
            if (idx == IDX_W'(h)) hid_reg[h] <= h_fire;
          if (idx == IDX_W'(HID_N - 1)) begin
            idx   <= '0;
            state <= S_L2;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end

        S_L2: begin
          out_acc <= out_next;
          if (idx == IDX_W'(OUT_N - 1)) begin
            out_data    <= out_next;
            out_valid_r <= 1'b1;
            idx         <= '0;
            state       <= S_DONE;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end

        S_DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            busy        <= 1'b0;
            state       <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  // busy is registered and tracks state != IDLE, so ~busy means idle.
  // A load request in the same cycle takes precedence over a new input.
  assign in_ready  = rst_n & ena & ~busy & ~ld_en & ~ld_start;
  assign out_valid = out_valid_r & ena;

endmodule

// File: doc/bnn_seq_core.md
# bnn_seq_core

Parametrised two-layer binary neural network core with a time-multiplexed datapath. It evaluates one neuron per cycle against a runtime-loadable configuration image, where each neuron has its own weights and its own programmable threshold. Input and output use valid/ready handshakes, so the core can sit between the pad-level input register and any result consumer in the top-level wrapper. It is the generalised successor of the fixed 8-8-4 BNN.

## Interface
- `IN_W`, 8: input vector width, which is also the fan-in of each hidden neuron.
- `HID_N`, 8: number of hidden neurons, which is also the fan-in of each output neuron.
- `OUT_N`, 4: number of output neurons.
- `LOAD_W`, 4: bits per configuration load beat.
- `THR_W`, $clog2(max(IN_W,HID_N)+1) = 4: width of each threshold field.
- `clk` in 1: the only clock.
- `rst_n` in 1: reset, synchronous and active-low.
- `ena` in 1: global enable. While low, all state freezes.
- `in_data` in IN_W: input vector.
- `in_valid` in 1 / `in_ready` out 1: input handshake.
- `out_data` out OUT_N: result vector.
- `out_valid` out 1 / `out_ready` in 1: output handshake.
- `ld_start` in 1: pulse that resets the load pointer to beat 0.
- `ld_en` in 1: qualifies one load beat.
- `ld_data` in LOAD_W: load beat payload.
- `busy` out 1: high in every state except IDLE.
- `ld_err` out 1: sticky load-error flag. Cleared by `ld_start` or by reset.

## Operation
- **Config image layout.** The image has TOTAL = HID_N*IN_W + HID_N*THR_W + OUT_N*HID_N + OUT_N*THR_W bits (144 with defaults). Fields are packed in this order, LSB first:
  - hidden weights: neuron h, bit i is at h*IN_W+i;
  - hidden thresholds;
  - output weights;
  - output thresholds.
- **Loading.** Beat k writes image bits [k*LOAD_W +: LOAD_W]. Any bits past TOTAL are dropped. There are NBEATS = ceil(TOTAL/LOAD_W) beats (36 with defaults).
- **Load pointer.**
  - A load beat is accepted only in IDLE with `ena=1`, and advances the pointer by 1.
  - A beat arriving with pointer == NBEATS is discarded and sets `ld_err`.
  - `ld_en` or `ld_start` while `busy=1` is ignored and sets `ld_err`.
  - If `ld_start` and `ld_en` are asserted in the same cycle, `ld_start` wins and the beat is dropped.
- **Reset image.** All weights are 0. Hidden thresholds are IN_W/2 and output thresholds are HID_N/2. The pointer is 0.
- **Neuron rule.** popcount(x XNOR w) is computed at full width (clog2(fan-in+1) bits), and the neuron fires iff popcount >= threshold.
  - A threshold of 0 always fires.
  - A threshold greater than the fan-in never fires.
- **FSM states.** The FSM has four states: IDLE, L1, L2 and DONE.
  - **IDLE.** `in_ready` = `ena` & ~`ld_en` & ~`ld_start`. On an input handshake, `in_data` is latched, the neuron index is set to 0, and the FSM enters L1.
  - **L1.** Each cycle evaluates hidden neuron[idx] into `hid_reg[idx]`. After idx = HID_N-1, idx is set to 0 and the FSM enters L2.
  - **L2.** Each cycle evaluates output neuron[idx] on `hid_reg`. After idx = OUT_N-1, the result register is loaded and the FSM enters DONE.
  - **DONE.** `out_valid`=1 and `out_data` is held stable. On `out_ready`=1 the FSM returns to IDLE.
- **Concurrency.** Only one inference is in flight at a time, so `in_ready`=0 in L1, L2 and DONE.
- **ena=0.** No register changes. `in_ready` and `out_valid` are forced to 0 combinationally. Operation resumes exactly where it stopped.
- **Reset (any state, including mid-inference or mid-load).** The FSM goes to IDLE and the image is restored to its reset values. `out_data`=0, `out_valid`=0, `in_ready`=0 during reset, `busy`=0, `ld_err`=0, and `hid_reg`=0.

## Timing
- The input handshake happens at edge E. Hidden neurons are evaluated on edges E+1..E+HID_N and output neurons on E+HID_N+1..E+HID_N+OUT_N.
- `out_valid` rises after edge E+HID_N+OUT_N, i.e. 12 cycles with defaults.
- The output handshake happens at edge F. `in_ready` is high from F+1, so the minimum inference period is HID_N+OUT_N+2 cycles.
- A load beat takes effect on the next edge and is used by any inference accepted afterwards.
- `ld_err` rises on the edge that samples the offending beat.
- All outputs are registered, except the combinational `ena` masking of `in_ready` and `out_valid`.

## Test plan
- **Reset image, all-zero input.** After reset, send `in_data`=0x00 → `out_data`=0x0, because all hidden neurons fire and all outputs see popcount 0. Then send 0xFF → `out_data`=0xF. `out_valid` must rise exactly 12 cycles after each accept.
- **Load and compute.**
  - Load 36 beats: hidden weights = 0xFF, hidden thresholds = 8, output weights = 0xFF, output thresholds = 8.
  - `in_data`=0xFF → 0xF.
  - `in_data`=0xFE → 0x0.
  - Afterwards `ld_err`=0.
- **Overflow.** Send a 37th beat → `ld_err`=1 and the image is unchanged (re-run the previous case). Then `ld_start` → `ld_err`=0.
- **Backpressure.** Hold `out_ready`=0 for 20 cycles in DONE → `out_valid` and `out_data` stay stable and `in_ready`=0. Raise `out_ready` → `in_ready`=1 on the next cycle.
- **Load while busy and ena freeze.**
  - `ld_en` pulse during L1 → `ld_err`=1 and the result is unchanged.
  - `ena`=0 for 5 cycles mid-L2 → the result and its latency shift by exactly 5 cycles.
- **Reset mid-inference.** Assert `rst_n`=0 during L2 → next cycle `busy`=0, `out_valid`=0, `out_data`=0, and the reset-image behaviour of the first case is restored.
